// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave):
// instruction/compare feedback in, mux selects and write strobes out.
interface multicycle_controller_if;
  logic [15:0] IRout;
  logic        compare;

  logic [2:0]  Mux1_alu_B;
  logic [2:0]  Mux2_alu_A;
  logic [1:0]  Mux3_RF_wen;
  logic [2:0]  Mux4_RF_wadd;
  logic [1:0]  Mux5_RF_read2;
  logic        Mux6_RF_dataIn;
  logic [1:0]  Mux8_memwrite;
  logic        Mux9_memDataIn;
  logic        CZ_en;
  logic        ALU_op;
  logic        wIR;
  logic        wAtmp;
  logic        T1write;
  logic [2:0]  counter;
  logic [4:0]  state_dbg;

  modport master (
    input  IRout,
    input  compare,
    output Mux1_alu_B,
    output Mux2_alu_A,
    output Mux3_RF_wen,
    output Mux4_RF_wadd,
    output Mux5_RF_read2,
    output Mux6_RF_dataIn,
    output Mux8_memwrite,
    output Mux9_memDataIn,
    output CZ_en,
    output ALU_op,
    output wIR,
    output wAtmp,
    output T1write,
    output counter,
    output state_dbg
  );

  modport slave (
    output IRout,
    output compare,
    input  Mux1_alu_B,
    input  Mux2_alu_A,
    input  Mux3_RF_wen,
    input  Mux4_RF_wadd,
    input  Mux5_RF_read2,
    input  Mux6_RF_dataIn,
    input  Mux8_memwrite,
    input  Mux9_memDataIn,
    input  CZ_en,
    input  ALU_op,
    input  wIR,
    input  wAtmp,
    input  T1write,
    input  counter,
    input  state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle RISC core: sequences fetch/execute/memory/write-back
// states per opcode and drives all datapath selects and strobes as registered outputs.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           proc_rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_F0   = 5'd1,
    S_F1   = 5'd2,
    S_F2   = 5'd3,
    S_EX   = 5'd4,
    S_WB   = 5'd5,
    S_MEM  = 5'd6,
    S_MA0  = 5'd7,
    S_MADR = 5'd8,
    S_MXF  = 5'd9,
    S_B1   = 5'd10,
    S_B2   = 5'd11,
    S_J0   = 5'd12,
    S_J1   = 5'd13,
    S_J2   = 5'd14,
    S_J3   = 5'd15
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [2:0] B_ZERO = 3'd0;
  localparam logic [2:0] B_B    = 3'd2;
  localparam logic [2:0] B_IMM6 = 3'd3;
  localparam logic [2:0] B_CNT  = 3'd4;

  localparam logic [2:0] A_ZERO = 3'd0;
  localparam logic [2:0] A_ONE  = 3'd1;
  localparam logic [2:0] A_SH7  = 3'd2;
  localparam logic [2:0] A_IMM6 = 3'd3;
  localparam logic [2:0] A_IMM9 = 3'd4;
  localparam logic [2:0] A_A    = 3'd5;
  localparam logic [2:0] A_TMPA = 3'd6;

  localparam logic [1:0] WEN_ON  = 2'd1;
  localparam logic [1:0] WEN_CZ  = 2'd2;
  localparam logic [1:0] WEN_BIT = 2'd3;

  localparam logic [2:0] WA_IR11 = 3'd0;
  localparam logic [2:0] WA_IR5  = 3'd1;
  localparam logic [2:0] WA_CNT  = 3'd2;
  localparam logic [2:0] WA_R7   = 3'd3;
  localparam logic [2:0] WA_IR8  = 3'd4;

  localparam logic [1:0] RD2_IR8 = 2'd0;
  localparam logic [1:0] RD2_CNT = 2'd1;
  localparam logic [1:0] RD2_R7  = 2'd2;

  localparam logic [1:0] MW_ON  = 2'd1;
  localparam logic [1:0] MW_BIT = 2'd2;

  typedef struct packed {
    logic [2:0] mux1;
    logic [2:0] mux2;
    logic [1:0] mux3;
    logic [2:0] mux4;
    logic [1:0] mux5;
    logic       mux6;
    logic [1:0] mux8;
    logic       mux9;
    logic       cz_en;
    logic       alu_op;
    logic       w_ir;
    logic       w_atmp;
    logic       t1_write;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [2:0] counter_q, counter_d;
  logic       take_q, take_d;
  ctrl_t      ctrl_q;
  logic [3:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = bus.IRout[15:12];
  assign unused_ir_bits = ^bus.IRout[11:0];

  // Moore decode of one state (opcode refines EX/WB/MEM/MXF/J2); registered below.
  function automatic ctrl_t decode(input state_t st, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_F0: begin
        c.mux5 = RD2_R7; c.mux2 = A_ZERO; c.mux1 = B_B; c.t1_write = 1'b1;
      end
      S_F1: begin
        c.w_ir = 1'b1;
        c.mux5 = RD2_R7; c.mux2 = A_ONE; c.mux1 = B_B; c.t1_write = 1'b1;
      end
      S_F2, S_B2, S_J3: begin
        c.mux4 = WA_R7; c.mux6 = 1'b1; c.mux3 = WEN_ON;
      end
      S_EX: begin
        case (op)
          OP_ADD, OP_NDU: begin
            c.mux2 = A_A; c.mux1 = B_B; c.mux5 = RD2_IR8;
            c.t1_write = 1'b1; c.cz_en = 1'b1; c.alu_op = (op == OP_NDU);
          end
          OP_ADI: begin
            c.mux2 = A_A; c.mux1 = B_IMM6; c.t1_write = 1'b1; c.cz_en = 1'b1;
          end
          OP_LHI: begin
            c.mux2 = A_SH7; c.mux1 = B_ZERO; c.t1_write = 1'b1;
          end
          OP_LW, OP_SW: begin
            c.mux2 = A_IMM6; c.mux1 = B_B; c.mux5 = RD2_IR8; c.t1_write = 1'b1;
          end
          OP_BEQ: begin
            c.mux2 = A_A; c.mux1 = B_B; c.mux5 = RD2_IR8;
          end
          default: ;
        endcase
      end
      S_WB: begin
        case (op)
          OP_ADD, OP_NDU: begin
            c.mux3 = WEN_CZ; c.mux4 = WA_IR5; c.mux6 = 1'b1;
          end
          OP_ADI: begin
            c.mux4 = WA_IR8; c.mux3 = WEN_ON; c.mux6 = 1'b1;
          end
          OP_LHI: begin
            c.mux4 = WA_IR11; c.mux3 = WEN_ON; c.mux6 = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_LW) begin
          c.mux6 = 1'b0; c.mux3 = WEN_ON;
        end else if (op == OP_SW) begin
          c.mux8 = MW_ON; c.mux9 = 1'b0;
        end
      end
      S_MA0: c.w_atmp = 1'b1;
      S_MADR: begin
        c.mux2 = A_TMPA; c.mux1 = B_CNT; c.t1_write = 1'b1;
      end
      S_MXF: begin
        if (op == OP_LM) begin
          c.mux3 = WEN_BIT; c.mux4 = WA_CNT; c.mux6 = 1'b0;
        end else if (op == OP_SM) begin
          c.mux8 = MW_BIT; c.mux9 = 1'b1; c.mux5 = RD2_CNT;
        end
      end
      S_B1: begin
        c.mux2 = A_IMM6; c.mux1 = B_B; c.mux5 = RD2_R7; c.t1_write = 1'b1;
      end
      S_J0: begin
        c.mux5 = RD2_R7; c.mux2 = A_ZERO; c.mux1 = B_B; c.t1_write = 1'b1;
      end
      S_J1: begin
        c.mux4 = WA_IR11; c.mux3 = WEN_ON; c.mux6 = 1'b1;
      end
      S_J2: begin
        if (op == OP_JAL) begin
          c.mux2 = A_IMM9; c.mux1 = B_B; c.mux5 = RD2_R7;
        end else begin
          c.mux2 = A_ZERO; c.mux1 = B_B; c.mux5 = RD2_IR8;
        end
        c.t1_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    take_d    = take_q;
    case (state_q)
      S_RST: state_d = S_F0;
      S_F0:  state_d = S_F1;
      S_F1:  state_d = S_F2;
      S_F2: begin
        case (opcode)
          OP_ADD, OP_ADI, OP_NDU, OP_LHI,
          OP_LW, OP_SW, OP_BEQ:      state_d = S_EX;
          OP_LM, OP_SM:              state_d = S_MA0;
          OP_JAL, OP_JLR:            state_d = S_J0;
          default:                   state_d = S_F0;
        endcase
      end
      S_EX: begin
        if (opcode == OP_BEQ) begin
          take_d  = bus.compare;
          state_d = take_d ? S_B1 : S_F0;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB, S_MEM: state_d = S_F0;
      S_MA0: begin
        counter_d = 3'd0;
        state_d   = S_MADR;
      end
      S_MADR: state_d = S_MXF;
      // Eight transfers: the index wraps to 0 as the loop exits.
      S_MXF: begin
        counter_d = counter_q + 3'd1;
        state_d   = (counter_q == 3'd7) ? S_F0 : S_MADR;
      end
      S_B1: state_d = S_B2;
      S_B2: state_d = S_F0;
      S_J0: state_d = S_J1;
      S_J1: state_d = S_J2;
      S_J2: state_d = S_J3;
      S_J3: state_d = S_F0;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q   <= S_RST;
      counter_q <= 3'd0;
      take_q    <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      take_q    <= take_d;
      ctrl_q    <= decode(state_d, opcode);
    end
  end

  assign bus.Mux1_alu_B     = ctrl_q.mux1;
  assign bus.Mux2_alu_A     = ctrl_q.mux2;
  assign bus.Mux3_RF_wen    = ctrl_q.mux3;
  assign bus.Mux4_RF_wadd   = ctrl_q.mux4;
  assign bus.Mux5_RF_read2  = ctrl_q.mux5;
  assign bus.Mux6_RF_dataIn = ctrl_q.mux6;
  assign bus.Mux8_memwrite  = ctrl_q.mux8;
  assign bus.Mux9_memDataIn = ctrl_q.mux9;
  assign bus.CZ_en          = ctrl_q.cz_en;
  assign bus.ALU_op         = ctrl_q.alu_op;
  assign bus.wIR            = ctrl_q.w_ir;
  assign bus.wAtmp          = ctrl_q.w_atmp;
  assign bus.T1write        = ctrl_q.t1_write;
  assign bus.counter        = counter_q;
  assign bus.state_dbg      = state_q;

endmodule
